nbout_accum_buffer: RTL
=======================

# nbout_accum_buffer

Output-neuron partial-sum buffer for one n0 unit. It accepts Tn-lane multiply-add results for writeback and serves the same partial sums back to the lanes on the next accumulation pass. When an entry's final partial sum arrives, the buffer drains it to the downstream output path over a valid/ready handshake. It sits between the unit's lane outputs and the NBout consumer, and closes the partial-sum loop.

## Interface
- N, 16, bits per value
- Tn, 16, lanes per entry (one value per lane)
- DEPTH, 4, entries; power of two; AW = log2(DEPTH)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_wr_valid  in  1  writeback request
- o_wr_ready  out  1  writeback accepted this cycle
- i_wr_idx  in  AW  target entry
- i_wr_data  in  N*Tn  lane results; lane k at [(k+1)*N-1 : k*N]
- i_wr_last  in  1  this write is the final partial sum for the entry
- i_rd_en  in  1  partial-sum read request
- i_rd_idx  in  AW  entry to read
- o_rd_valid  out  1  o_rd_data valid
- o_rd_data  out  N*Tn  partial sums, same lane packing
- o_out_valid  out  1  finished entry presented
- i_out_ready  in  1  downstream accepts
- o_out_idx  out  AW  index of presented entry
- o_out_data  out  N*Tn  finished entry contents

## Operation
- Per-entry state: EMPTY, ACCUM, DONE. Storage: DEPTH x (N*Tn) registers.
- Write:
  - o_wr_ready = (state[i_wr_idx] != DONE), combinational.
  - Accepted on i_wr_valid & o_wr_ready: data stored; state becomes DONE if i_wr_last, else ACCUM.
  - Writes to ACCUM overwrite. No arithmetic in the block; the lanes' wrapping N-bit adders produce the data.
- Read, registered:
  - i_rd_en at edge E gives o_rd_valid=1 and o_rd_data after E.
  - An EMPTY entry returns all zeros, which is the accumulator seed.
  - ACCUM and DONE entries return stored data.
  - No i_rd_en gives o_rd_valid=0; o_rd_data holds its last value.
- Read/write to the same index in the same cycle returns the pre-write contents.
- Drain FSM, states IDLE and SEND, with pointer ptr (AW bits, wraps modulo DEPTH):
  - IDLE: if state[ptr]==DONE, load o_out_data/o_out_idx from entry ptr, assert o_out_valid, go to SEND. Otherwise ptr <= ptr+1.
  - SEND: hold o_out_valid, o_out_idx and o_out_data stable until i_out_ready. On the handshake edge: entry ptr becomes EMPTY, its data is zeroed, ptr <= ptr+1, o_out_valid <= 0, go to IDLE.
- A DONE entry refuses writes, so a write racing a drain to the same index stalls (o_wr_ready=0). The entry becomes writable the cycle after the handshake.
- Reset values: every entry EMPTY with zero data; ptr=0; FSM IDLE; o_rd_valid=0; o_rd_data=0; o_out_valid=0; o_out_idx=0; o_out_data=0. o_wr_ready=1 after reset.
- Reset mid-operation, including during SEND: all contents and pending drains are discarded and all outputs go to reset values on the next edge. Inputs in the reset cycle are ignored.

## Timing
- Read latency: 1 cycle.
- Write-to-DONE: visible the cycle after the accepting edge E.
- Drain latency, best case (ptr already at idx): o_out_valid rises after edge E+1. Worst case: E+DEPTH.
- Drain throughput: at most one entry per 2 cycles (IDLE bubble after each SEND).
- o_wr_ready is combinational from state and i_wr_idx. It has no combinational path from i_wr_valid or i_out_ready.
- o_out_valid never drops without a handshake, except on rst.

## Test plan
- Reset, then read idx 2 -> o_rd_valid=1 next cycle, o_rd_data=0. o_out_valid=0 and o_wr_ready=1 throughout.
- Write idx 1 with lanes = 0x0001..0x0010 (last=0), read idx 1 -> same 256-bit value. Rewrite lanes +1, read again -> updated values. No drain occurs.
- Write idx 0 with last=1 while ptr=0 -> o_out_valid high two edges after the write, o_out_idx=0, data matches. Hold i_out_ready=0 for 5 cycles -> outputs stable. Assert ready -> entry 0 reads zero afterwards.
- Entry 3 DONE with i_out_ready=0, then write idx 3 -> o_wr_ready=0 until the cycle after the handshake, then the write is accepted.
- Entries 2 and 0 marked DONE in the same window, ptr=1 -> drain order 2 then 0, with one-cycle bubbles between.
- rst asserted during SEND with i_out_ready=0 -> next cycle o_out_valid=0, all reads return 0, ptr=0.

Source files
------------

// File: rtl/nbout_accum_buffer.sv
// Partial-sum buffer for one n0 unit: stores lane writebacks, serves them back
// for the next accumulation pass, and drains finished entries downstream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// DR_IDLE | scanning: ptr advances each cycle until it lands on a DONE entry
// DR_SEND | entry ptr presented on o_out_*; held until i_out_ready
module nbout_accum_buffer #(
  parameter int N     = 16,
  parameter int TN    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [AW-1:0]       i_wr_idx,
  input  logic [N*TN-1:0]     i_wr_data,
  input  logic                i_wr_last,
  input  logic                i_rd_en,
  input  logic [AW-1:0]       i_rd_idx,
  output logic                o_rd_valid,
  output logic [N*TN-1:0]     o_rd_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [AW-1:0]       o_out_idx,
  output logic [N*TN-1:0]     o_out_data
);

  typedef enum logic [1:0] {
    ENT_EMPTY = 2'd0,
    ENT_ACCUM = 2'd1,
    ENT_DONE  = 2'd2
  } ent_e;

  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_SEND = 1'b1
  } drain_e;

  ent_e            ent_state [DEPTH];
  logic [N*TN-1:0] mem       [DEPTH];

  drain_e          drain_q, drain_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            drain_load;
  logic            drain_clear;
  logic            wr_fire;

  // DONE entries refuse writes, so a write can never collide with the drain clearing its entry.
  assign o_wr_ready = (ent_state[i_wr_idx] != ENT_DONE);
  assign wr_fire    = i_wr_valid & o_wr_ready;

  always_comb begin
    drain_d     = drain_q;
    ptr_d       = ptr_q;
    drain_load  = 1'b0;
    drain_clear = 1'b0;
    case (drain_q)
      DR_IDLE: begin
        if (ent_state[ptr_q] == ENT_DONE) begin
          drain_load = 1'b1;
          drain_d    = DR_SEND;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      DR_SEND: begin
        if (i_out_ready) begin
          drain_clear = 1'b1;
          ptr_d       = ptr_q + AW'(1);
          drain_d     = DR_IDLE;
        end
      end
      default: drain_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i] <= ENT_EMPTY;
        mem[i]       <= '0;
      end
      drain_q     <= DR_IDLE;
      ptr_q       <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_out_valid <= 1'b0;
      o_out_idx   <= '0;
      o_out_data  <= '0;
    end else begin
      drain_q <= drain_d;
      ptr_q   <= ptr_d;

      // Reads sample pre-write contents; an EMPTY entry seeds the accumulator with zero.
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= (ent_state[i_rd_idx] == ENT_EMPTY) ? '0 : mem[i_rd_idx];
      end

      if (wr_fire) begin
        mem[i_wr_idx]       <= i_wr_data;
        ent_state[i_wr_idx] <= i_wr_last ? ENT_DONE : ENT_ACCUM;
      end

      if (drain_load) begin
        o_out_valid <= 1'b1;
        o_out_idx   <= ptr_q;
        o_out_data  <= mem[ptr_q];
      end

      if (drain_clear) begin
        o_out_valid      <= 1'b0;
        ent_state[ptr_q] <= ENT_EMPTY;
        mem[ptr_q]       <= '0;
      end
    end
  end

endmodule
